// File: rtl/bram_port_arbiter.sv
// Shares one bram_tdp port among NREQ requesters: round-robin with bounded burst hold.
// Define BRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module bram_port_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR      = 10,
    parameter int DATA      = 72,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      wr,
    input  logic [NREQ*ADDR-1:0] addr,
    input  logic [NREQ*DATA-1:0] din,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DATA-1:0]      rdata,
    output logic                 mem_wr,
    output logic [ADDR-1:0]      mem_addr,
    output logic [DATA-1:0]      mem_din,
    input  logic [DATA-1:0]      mem_dout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic            hit;
    logic [IW-1:0]   win;
    logic [IW-1:0]   sel;
    logic [IW:0]     p_rr;

    // Returns {found, index} of the first set bit scanning span slots from base.
    function automatic logic [IW:0] pick(
        input logic [NREQ-1:0] r,
        input int              base,
        input int              span
    );
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (base + k) % NREQ;
            if (k < span && r[j] && !res[IW]) begin
                res = {1'b1, IW'(j)};
            end
        end
        return res;
    endfunction

`ifdef BRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        p_rr    = pick(req, 0, NREQ);
        hit     = p_rr[IW];
        win     = p_rr[IW-1:0];
        unique case (state_q)
            IDLE: if (hit) begin
                state_d = HOLD;
                owner_d = win;
            end
            HOLD: if (hit) begin
                owner_d = win;
            end else begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`else
    localparam logic [3:0] MB = 4'(MAX_BURST);

    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW:0]   p_nx;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
        return IW'((int'(x) + 1) % NREQ);
    endfunction

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        hit     = 1'b0;
        win     = '0;
        p_rr    = pick(req, int'(rr_q), NREQ);
        p_nx    = pick(req, int'(owner_q) + 1, NREQ - 1);
        unique case (state_q)
            IDLE: if (p_rr[IW]) begin
                hit     = 1'b1;
                win     = p_rr[IW-1:0];
                state_d = HOLD;
                owner_d = p_rr[IW-1:0];
                cnt_d   = 4'd1;
                rr_d    = nxt(p_rr[IW-1:0]);
            end
            HOLD: begin
                // Owner keeps the port until its burst is spent and someone waits.
                if (req[owner_q] && (cnt_q < MB || !p_nx[IW])) begin
                    hit = 1'b1;
                    win = owner_q;
                    if (cnt_q < MB) cnt_d = cnt_q + 4'd1;
                end else if (p_nx[IW]) begin
                    hit     = 1'b1;
                    win     = p_nx[IW-1:0];
                    owner_d = p_nx[IW-1:0];
                    cnt_d   = 4'd1;
                    rr_d    = nxt(p_nx[IW-1:0]);
                end else begin
                    state_d = IDLE;
                    rr_d    = nxt(owner_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
        end
    end
`endif

    always_comb begin
        gnt = '0;
        if (hit && rst_n) gnt[win] = 1'b1;
    end

    assign sel      = hit ? win : '0;
    assign mem_addr = rst_n ? addr[sel*ADDR +: ADDR] : '0;
    assign mem_din  = rst_n ? din[sel*DATA +: DATA] : '0;
    assign mem_wr   = |(req & gnt & wr);
    assign pend_d   = req & gnt & ~wr;
    assign rvalid   = pend_q;
    assign rdata    = mem_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural 1-cycle-latency BRAM port.
// Define BRAM_ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_bram_port_arbiter;

    localparam int NREQ = 4;
    localparam int ADDR = 10;
    localparam int DATA = 72;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      wr;
    logic [NREQ*ADDR-1:0] addr;
    logic [NREQ*DATA-1:0] din;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DATA-1:0]      rdata;
    logic                 mem_wr;
    logic [ADDR-1:0]      mem_addr;
    logic [DATA-1:0]      mem_din;
    logic [DATA-1:0]      mem_dout;

    logic [DATA-1:0] mem [0:(1<<ADDR)-1];

    int n_cmp = 0;
    int n_bad = 0;

    bram_port_arbiter #(
        .NREQ(NREQ), .ADDR(ADDR), .DATA(DATA), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .wr(wr), .addr(addr), .din(din),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        req   = '0;
        wr    = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 4'b1111;
        wr    = 4'b1111;
        addr  = {10'h3A1, 10'h2B2, 10'h1C3, 10'h0D4};
        din   = {NREQ{72'hFF_FFFF_FFFF_FFFF_FFFF}};
        tick();
        tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt got %b want 0000", gnt); end
        n_cmp++; if (rvalid !== 4'b0000) begin n_bad++; $display("FAIL rst_rvalid got %b want 0000", rvalid); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mem_wr got %b want 0", mem_wr); end
        n_cmp++; if (mem_addr !== 10'h000) begin n_bad++; $display("FAIL rst_mem_addr got %h want 000", mem_addr); end
        n_cmp++; if (mem_din !== 72'h0) begin n_bad++; $display("FAIL rst_mem_din got %h want 0", mem_din); end
        req = '0;
        wr  = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read;
        apply_reset();
        tick();
        req = 4'b0001;
        wr  = 4'b0000;
        addr[0 +: ADDR] = 10'h005;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rd_gnt got %b want 0001", gnt); end
        n_cmp++; if (mem_addr !== 10'h005) begin n_bad++; $display("FAIL rd_addr got %h want 005", mem_addr); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rd_mem_wr got %b want 0", mem_wr); end
        tick();
        req = 4'b0000;
        n_cmp++; if (rvalid !== 4'b0001) begin n_bad++; $display("FAIL rd_rvalid got %b want 0001", rvalid); end
        n_cmp++; if (rdata !== 72'hAB) begin n_bad++; $display("FAIL rd_rdata got %h want ab", rdata); end
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rd_idle_gnt got %b want 0000", gnt); end
        tick();
        n_cmp++; if (rvalid !== 4'b0000) begin n_bad++; $display("FAIL rd_rvalid_end got %b want 0000", rvalid); end
    endtask

    task automatic test_write_read;
        apply_reset();
        tick();
        req = 4'b0001;
        wr  = 4'b0001;
        addr[0 +: ADDR] = 10'h3FF;
        din[0 +: DATA]  = 72'h12_3456_789A_BCDE_F012;
        #1;
        n_cmp++; if (mem_wr !== 1'b1) begin n_bad++; $display("FAIL wr_mem_wr got %b want 1", mem_wr); end
        n_cmp++; if (mem_din !== 72'h12_3456_789A_BCDE_F012) begin n_bad++; $display("FAIL wr_mem_din got %h", mem_din); end
        n_cmp++; if (mem_addr !== 10'h3FF) begin n_bad++; $display("FAIL wr_mem_addr got %h want 3ff", mem_addr); end
        tick();
        wr = 4'b0000;
        n_cmp++; if (rvalid !== 4'b0000) begin n_bad++; $display("FAIL wr_no_rvalid got %b want 0000", rvalid); end
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL wr_rd_gnt got %b want 0001", gnt); end
        tick();
        req = 4'b0000;
        n_cmp++; if (rvalid !== 4'b0001) begin n_bad++; $display("FAIL wr_rd_rvalid got %b want 0001", rvalid); end
        n_cmp++; if (rdata !== 72'h12_3456_789A_BCDE_F012) begin n_bad++; $display("FAIL wr_rd_rdata got %h", rdata); end
        tick();
    endtask

    task automatic test_contention;
        logic [NREQ-1:0] exp_g;
        logic [NREQ-1:0] prev_g;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            addr[i*ADDR +: ADDR] = ADDR'(10'h010 + i);
            mem[10'h010 + i] = DATA'(72'h100 + i);
        end
        prev_g = '0;
        for (int c = 0; c < 17; c++) begin
            tick();
            if (c > 0) begin
                n_cmp++; if (rvalid !== prev_g) begin n_bad++; $display("FAIL cont_rvalid c=%0d got %b want %b", c, rvalid, prev_g); end
            end
            req = 4'b1111;
            wr  = 4'b0000;
            #1;
            exp_g = 4'b0001 << ((c / 4) % 4);
            n_cmp++; if (gnt !== exp_g) begin n_bad++; $display("FAIL cont_gnt c=%0d got %b want %b", c, gnt, exp_g); end
            prev_g = exp_g;
        end
        tick();
        req = 4'b0000;
        n_cmp++; if (rvalid !== 4'b0001) begin n_bad++; $display("FAIL cont_last_rvalid got %b want 0001", rvalid); end
        n_cmp++; if (rdata !== 72'h100) begin n_bad++; $display("FAIL cont_last_rdata got %h want 100", rdata); end
        tick();
    endtask

    task automatic test_lone_streamer;
        int bad;
        apply_reset();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            req = 4'b0001;
            wr  = 4'b0000;
            #1;
            if (gnt !== 4'b0001) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL lone_gnt got %0d bad cycles want 0", bad); end
        tick();
        n_cmp++; if (rvalid !== 4'b0001) begin n_bad++; $display("FAIL lone_rvalid got %b want 0001", rvalid); end
        req = 4'b0011;
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL lone_sat_gnt got %b want 0010", gnt); end
        tick();
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid;
        apply_reset();
        tick();
        req = 4'b0001;
        wr  = 4'b0000;
        tick();
        req = 4'b0000;
        n_cmp++; if (rvalid !== 4'b0001) begin n_bad++; $display("FAIL mid_pending got %b want 0001", rvalid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rvalid !== 4'b0000) begin n_bad++; $display("FAIL mid_rvalid got %b want 0000", rvalid); end
        tick();
        rst_n = 1'b1;
        tick();
        req = 4'b0100;
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL mid_gnt got %b want 0100", gnt); end
        tick();
        req = 4'b0000;
        tick();
    endtask

    task automatic test_rr_pointer;
        apply_reset();
        tick();
        req = 4'b1000;
        #1;
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_first got %b want 1000", gnt); end
        tick();
        req = 4'b0000;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL wrap_idle got %b want 0000", gnt); end
        tick();
        req = 4'b1001;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt got %b want 0001", gnt); end
        apply_reset();
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0011;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rr_ptr_gnt got %b want 0001", gnt); end
        tick();
        req = 4'b0000;
        tick();
    endtask

    task automatic test_fixed_prio;
        int bad;
        apply_reset();
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            req = 4'b1110;
            wr  = 4'b0000;
            #1;
            if (gnt !== 4'b0010) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL fixed_gnt got %0d bad cycles want 0", bad); end
        tick();
        req = 4'b0101;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL fixed_low got %b want 0001", gnt); end
        tick();
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        wr    = '0;
        addr  = '0;
        din   = '0;
        for (int i = 0; i < (1 << ADDR); i++) mem[i] = '0;
        mem[10'h005] = 72'hAB;
        test_reset();
        test_single_read();
        test_write_read();
        test_reset_mid();
`ifdef BRAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_contention();
        test_lone_streamer();
        test_rr_pointer();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
